// File: rtl/dmux_pkg.sv
// Shared constants and types for the registered 1-to-16 demux.
package dmux_pkg;
    localparam int DMUX_DEFAULT_BUS_WIDTH = 4;
    localparam int DMUX16_LANES           = 16;
    localparam int DMUX16_SEL_W           = 4;

    typedef logic [DMUX16_SEL_W-1:0] sel_t;
endpackage

// File: rtl/dmux4_comb.sv
// Combinational 1-to-4 demux; unselected outputs are driven to zero.
module dmux4_comb #(
    parameter int BUS_WIDTH = 4
) (
    input  logic [BUS_WIDTH-1:0] in,
    input  logic [1:0]           sel,
    output logic [BUS_WIDTH-1:0] out0,
    output logic [BUS_WIDTH-1:0] out1,
    output logic [BUS_WIDTH-1:0] out2,
    output logic [BUS_WIDTH-1:0] out3
);
    always_comb begin
        out0 = '0;
        out1 = '0;
        out2 = '0;
        out3 = '0;
        case (sel)
            2'd0: out0 = in;
            2'd1: out1 = in;
            2'd2: out2 = in;
            2'd3: out3 = in;
        endcase
    end
endmodule

// File: rtl/dmux16_reg.sv
// Registered 1-to-16 demux built from a two-level dmux4_comb tree.
// Optional DMUX16_REG_ONEHOT_EN adds a registered one-hot copy of sel.
module dmux16_reg
    import dmux_pkg::*;
#(
    parameter int BUS_WIDTH = DMUX_DEFAULT_BUS_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [BUS_WIDTH-1:0] in,
    input  sel_t                 sel,
    output logic [BUS_WIDTH-1:0] out0,
    output logic [BUS_WIDTH-1:0] out1,
    output logic [BUS_WIDTH-1:0] out2,
    output logic [BUS_WIDTH-1:0] out3,
    output logic [BUS_WIDTH-1:0] out4,
    output logic [BUS_WIDTH-1:0] out5,
    output logic [BUS_WIDTH-1:0] out6,
    output logic [BUS_WIDTH-1:0] out7,
    output logic [BUS_WIDTH-1:0] out8,
    output logic [BUS_WIDTH-1:0] out9,
    output logic [BUS_WIDTH-1:0] out10,
    output logic [BUS_WIDTH-1:0] out11,
    output logic [BUS_WIDTH-1:0] out12,
    output logic [BUS_WIDTH-1:0] out13,
    output logic [BUS_WIDTH-1:0] out14,
    output logic [BUS_WIDTH-1:0] out15
`ifdef DMUX16_REG_ONEHOT_EN
    ,
    output logic [DMUX16_LANES-1:0] sel_onehot
`endif
);
    logic [3:0][BUS_WIDTH-1:0]              grp;
    logic [DMUX16_LANES-1:0][BUS_WIDTH-1:0] lane;
    logic [DMUX16_LANES-1:0][BUS_WIDTH-1:0] lane_q;

    // Level 1 picks the group from sel[3:2]; level 2 picks the lane within it.
    dmux4_comb #(.BUS_WIDTH(BUS_WIDTH)) u_l1 (
        .in   (in),
        .sel  (sel[3:2]),
        .out0 (grp[0]),
        .out1 (grp[1]),
        .out2 (grp[2]),
        .out3 (grp[3])
    );

    for (genvar g = 0; g < 4; g++) begin : g_l2
        dmux4_comb #(.BUS_WIDTH(BUS_WIDTH)) u_l2 (
            .in   (grp[g]),
            .sel  (sel[1:0]),
            .out0 (lane[g*4+0]),
            .out1 (lane[g*4+1]),
            .out2 (lane[g*4+2]),
            .out3 (lane[g*4+3])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)
            lane_q <= '0;
        else if (en)
            lane_q <= lane;
    end

`ifdef DMUX16_REG_ONEHOT_EN
    always_ff @(posedge clk) begin
        if (rst)
            sel_onehot <= '0;
        else if (en)
            sel_onehot <= DMUX16_LANES'(1) << sel;
    end
`endif

    assign out0  = lane_q[0];
    assign out1  = lane_q[1];
    assign out2  = lane_q[2];
    assign out3  = lane_q[3];
    assign out4  = lane_q[4];
    assign out5  = lane_q[5];
    assign out6  = lane_q[6];
    assign out7  = lane_q[7];
    assign out8  = lane_q[8];
    assign out9  = lane_q[9];
    assign out10 = lane_q[10];
    assign out11 = lane_q[11];
    assign out12 = lane_q[12];
    assign out13 = lane_q[13];
    assign out14 = lane_q[14];
    assign out15 = lane_q[15];
endmodule

// File: tb/tb_dmux16_reg.sv
// Directed self-checking bench for dmux16_reg (BUS_WIDTH=4).
module tb_dmux16_reg;
    import dmux_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] in;
    sel_t         sel;
    logic [W-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [W-1:0] out8, out9, out10, out11, out12, out13, out14, out15;
`ifdef DMUX16_REG_ONEHOT_EN
    logic [15:0]  sel_onehot;
`endif

    logic [63:0] outs;
    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    dmux16_reg #(.BUS_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .in(in), .sel(sel),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out4(out4), .out5(out5), .out6(out6), .out7(out7),
        .out8(out8), .out9(out9), .out10(out10), .out11(out11),
        .out12(out12), .out13(out13), .out14(out14), .out15(out15)
`ifdef DMUX16_REG_ONEHOT_EN
        , .sel_onehot(sel_onehot)
`endif
    );

    assign outs = {out15, out14, out13, out12, out11, out10, out9, out8,
                   out7, out6, out5, out4, out3, out2, out1, out0};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected lane vector with value v placed in lane k.
    function automatic logic [63:0] lanes(input int k, input logic [3:0] v);
        logic [63:0] r;
        r = '0;
        r[k*4 +: 4] = v;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_oh(input string tag, input logic [15:0] exp);
`ifdef DMUX16_REG_ONEHOT_EN
        chk(tag, {48'b0, sel_onehot}, {48'b0, exp});
`endif
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; in = 4'hF; sel = 4'd5;
        tick();
        chk("reset_c1", outs, 64'h0);
        chk_oh("reset_c1_oh", 16'h0000);
        tick();
        chk("reset_c2", outs, 64'h0);
        chk_oh("reset_c2_oh", 16'h0000);

        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sel = sel_t'(i);
            in  = 4'(i);
            tick();
            chk($sformatf("sweep_%0d", i), outs, lanes(i, 4'(i)));
            chk_oh($sformatf("sweep_oh_%0d", i), 16'h1 << i);
        end
        chk("sweep_out15", {60'b0, out15}, 64'hF);

        sel = 4'd0; in = 4'h0;
        tick();
        chk("sweep0_allzero", outs, 64'h0);

        sel = 4'd3; in = 4'hA;
        tick();
        chk("hold_load", outs, lanes(3, 4'hA));
        en = 1'b0; sel = 4'd7; in = 4'h5;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("hold_c%0d", c), outs, lanes(3, 4'hA));
            chk_oh($sformatf("hold_oh_c%0d", c), 16'h0008);
        end

        en = 1'b1; sel = 4'd2; in = 4'h9;
        tick();
        chk("resteer_a", outs, lanes(2, 4'h9));
        sel = 4'd12; in = 4'h6;
        tick();
        chk("resteer_b", outs, lanes(12, 4'h6));
        chk_oh("resteer_b_oh", 16'h1000);

        sel = 4'd9; in = 4'hC;
        tick();
        chk("midrst_load", outs, lanes(9, 4'hC));
        en = 1'b0; rst = 1'b1;
        tick();
        chk("midrst_clear", outs, 64'h0);
        chk_oh("midrst_clear_oh", 16'h0000);
        rst = 1'b0; en = 1'b1; sel = 4'd9; in = 4'h1;
        tick();
        chk("midrst_reload", outs, lanes(9, 4'h1));

        sel = 4'd10; in = 4'h0;
        tick();
        chk("zero_data", outs, 64'h0);
        chk_oh("zero_data_oh", 16'h0400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/dmux16_reg.md
Name: dmux16_reg

Overview:
- Registered 1-to-16 demultiplexer: routes a BUS_WIDTH-bit input word to one of 16 output lanes selected by a 4-bit select; all other lanes are driven to zero.
- Built as a two-level tree of combinational 1-to-4 demux stages, with a single output register stage.
- Sits in the CPU datapath wherever one source fans out to one of up to 16 destinations, such as register-file write steering or RAM bank selection.

Parameters:
- BUS_WIDTH, 4, width in bits of the input word and of each output lane (must be >= 1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  update enable; when low, all output registers hold their value
- in  input  BUS_WIDTH  data word to be routed
- sel  input  4  lane index, 0..15
- out0 .. out15  output  BUS_WIDTH each  registered lane outputs; outK is lane K

Behaviour:
- Combinational core: lane[sel] = in; lane[k] = 0 for every k != sel. All 16 lanes are evaluated together and no X is produced for a defined sel.
- Tree structure:
  - First level: one 1-to-4 demux splits `in` by sel[3:2] into four group buses.
  - Second level: four 1-to-4 demuxes split each group bus by sel[1:0].
  - Lane index = sel[3:2]*4 + sel[1:0].
- Register stage: at each rising clk edge:
  - rst=1: all out0..out15 <= 0. Reset has priority over en.
  - rst=0, en=1: outK <= lane[K] for all K.
  - rst=0, en=0: all outK hold their value.
- Latency: 1 cycle from in/sel sampled with en=1 to the outputs. There is no combinational path from inputs to outputs.
- Changing sel between enabled cycles clears the previously selected lane on the next enabled edge. Lanes never accumulate or hold stale data while en=1.
- in=0 with en=1 drives all 16 lanes to zero, which is indistinguishable from reset; this is intended.
- Reset asserted mid-stream: outputs are zero on the edge after rst is sampled high. The first enabled edge after rst deasserts loads normally.
- sel is always in range (4 bits, 16 lanes), so there is no out-of-range case.
- BUS_WIDTH=1 is legal, and lanes behave as single-bit strobes.
- Reset value of every output: 0. Reset value of sel_onehot (when compiled in): 16'h0000.

Optional Feature:
- Macro: DMUX16_REG_ONEHOT_EN.
- With the macro defined, an extra output sel_onehot [15:0] is present:
  - Registered with the same rst/en rules as the lanes.
  - Bit K is 1 exactly when sel==K was loaded on the last enabled edge.
  - Reset value is 16'h0000.
  - It is independent of data value, so lane K with in=0 can still be identified.
- Without the macro, the port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package dmux_pkg holds:
  - DMUX_DEFAULT_BUS_WIDTH = 4
  - DMUX16_LANES = 16
  - DMUX16_SEL_W = 4
  - a sel_t typedef of [3:0]
- One sub-module, dmux4_comb: purely combinational 1-to-4 demux with ports BUS_WIDTH in, 2-bit sel, four outputs; non-selected outputs are 0.
- The top instantiates five dmux4_comb and the output register bank.

Test Plan:
- Reset: drive rst=1 for 2 cycles with in=4'hF, sel=5, en=1 -> all out0..out15 = 0 and sel_onehot=0.
- Sweep: rst=0, en=1; for i=0..15 set sel=i and in=i. One cycle later outi = i and every other lane = 0. Check at i=15 that out15=4'hF, and at i=0 that all lanes are 0.
- Hold: load sel=3, in=4'hA with en=1 -> out3=4'hA. Then set en=0, sel=7, in=4'h5 for 3 cycles -> out3 stays 4'hA and out7 stays 0.
- Re-steer clears: sel=2, in=4'h9 -> out2=9. Next enabled cycle sel=12, in=4'h6 -> out12=6 and out2=0.
- Reset mid-operation: with out9=4'hC held, assert rst=1 with en=0 -> all lanes 0 the next cycle. Deassert, load sel=9, in=4'h1 -> out9=1.
- DMUX16_REG_ONEHOT_EN: sel=10, in=0, en=1 -> all lanes 0 and sel_onehot=16'h0400.
